alu_reservation_station: RTL and testbench

- Operand-collection buffer directly upstream of the ALU.
- Accepts decoded ALU ops whose operands may still be pending, and snoops the common result bus (CDB) to fill in missing operands.
- Issues one fully-ready op per cycle to the ALU as op_spec / lhs / rhs with lhs_valid / rhs_valid both 1, plus a destination tag.

---
 rtl/alu_reservation_station.sv | 180 ++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collects operands from decode and the CDB, issues one ready op per cycle.
// Define ALU_RS_OLDEST_FIRST_EN for age-ordered issue; default issues the lowest-index ready entry.

package alu_rs_pkg;
    typedef struct packed {
        logic [3:0] opcode;
        logic       i_format;
    } operation_specification;
endpackage

module alu_reservation_station
    import alu_rs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  operation_specification        alloc_op_spec,
    input  logic [DATA_WIDTH-1:0]         alloc_lhs,
    input  logic                          alloc_lhs_valid,
    input  logic [TAG_WIDTH-1:0]          alloc_lhs_tag,
    input  logic [DATA_WIDTH-1:0]         alloc_rhs,
    input  logic                          alloc_rhs_valid,
    input  logic [TAG_WIDTH-1:0]          alloc_rhs_tag,
    input  logic [TAG_WIDTH-1:0]          alloc_dest_tag,
    input  logic                          cdb_valid,
    input  logic [TAG_WIDTH-1:0]          cdb_tag,
    input  logic [DATA_WIDTH-1:0]         cdb_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output operation_specification        issue_op_spec,
    output logic [DATA_WIDTH-1:0]         issue_lhs,
    output logic [DATA_WIDTH-1:0]         issue_rhs,
    output logic [TAG_WIDTH-1:0]          issue_dest_tag,
    output logic [$clog2(DEPTH):0]        occupancy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = IDX_W + 1;

    logic [DEPTH-1:0]             busy_q;
    operation_specification       op_q      [DEPTH];
    logic [DATA_WIDTH-1:0]        lhs_q     [DEPTH];
    logic [DATA_WIDTH-1:0]        rhs_q     [DEPTH];
    logic [DEPTH-1:0]             lhs_v_q;
    logic [DEPTH-1:0]             rhs_v_q;
    logic [TAG_WIDTH-1:0]         lhs_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]         rhs_tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]         dest_q    [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_fire;
    logic             issue_fire;

    assign ready = busy_q & lhs_v_q & rhs_v_q;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + OCC_W'(busy_q[i]);
        end
    end

    assign alloc_ready = (occupancy < OCC_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = issue_valid && issue_ready;

    // Only registered-free slots are candidates, so the entry issuing this cycle is never reused.
    always_comb begin
        logic found;
        found     = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!busy_q[i] && !found) begin
                found     = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    // older_q[i][j] set means entry i was allocated before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];

    always_comb begin
        logic outranked;
        issue_valid = 1'b0;
        issue_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            outranked = 1'b0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (j != i && ready[j] && older_q[j][i]) outranked = 1'b1;
            end
            if (ready[i] && !outranked && !issue_valid) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(DEPTH); i++) older_q[i] <= '0;
        end else if (alloc_fire) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (IDX_W'(j) != alloc_idx) begin
                    older_q[j][alloc_idx] <= 1'b1;
                    older_q[alloc_idx][j] <= 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ready[i] && !issue_valid) begin
                issue_valid = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end
`endif

    assign issue_op_spec  = op_q[issue_idx];
    assign issue_lhs      = lhs_q[issue_idx];
    assign issue_rhs      = rhs_q[issue_idx];
    assign issue_dest_tag = dest_q[issue_idx];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_q  <= '0;
            lhs_v_q <= '0;
            rhs_v_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (issue_fire && issue_idx == IDX_W'(i)) busy_q[i] <= 1'b0;
                if (cdb_valid && busy_q[i] && !lhs_v_q[i] && lhs_tag_q[i] == cdb_tag) begin
                    lhs_q[i]   <= cdb_data;
                    lhs_v_q[i] <= 1'b1;
                end
                if (cdb_valid && busy_q[i] && !rhs_v_q[i] && rhs_tag_q[i] == cdb_tag) begin
                    rhs_q[i]   <= cdb_data;
                    rhs_v_q[i] <= 1'b1;
                end
                // The alloc slot is not busy, so it never collides with the wakeup above.
                if (alloc_fire && alloc_idx == IDX_W'(i)) begin
                    busy_q[i]    <= 1'b1;
                    op_q[i]      <= alloc_op_spec;
                    lhs_tag_q[i] <= alloc_lhs_tag;
                    rhs_tag_q[i] <= alloc_rhs_tag;
                    dest_q[i]    <= alloc_dest_tag;
                    if (!alloc_lhs_valid && cdb_valid && alloc_lhs_tag == cdb_tag) begin
                        lhs_q[i]   <= cdb_data;
                        lhs_v_q[i] <= 1'b1;
                    end else begin
                        lhs_q[i]   <= alloc_lhs;
                        lhs_v_q[i] <= alloc_lhs_valid;
                    end
                    if (!alloc_rhs_valid && cdb_valid && alloc_rhs_tag == cdb_tag) begin
                        rhs_q[i]   <= cdb_data;
                        rhs_v_q[i] <= 1'b1;
                    end else begin
                        rhs_q[i]   <= alloc_rhs;
                        rhs_v_q[i] <= alloc_rhs_valid;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station; issue order checks follow ALU_RS_OLDEST_FIRST_EN.

module tb_alu_reservation_station;
    import alu_rs_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   alloc_valid;
    logic                   alloc_ready;
    operation_specification alloc_op_spec;
    logic [63:0]            alloc_lhs;
    logic                   alloc_lhs_valid;
    logic [3:0]             alloc_lhs_tag;
    logic [63:0]            alloc_rhs;
    logic                   alloc_rhs_valid;
    logic [3:0]             alloc_rhs_tag;
    logic [3:0]             alloc_dest_tag;
    logic                   cdb_valid;
    logic [3:0]             cdb_tag;
    logic [63:0]            cdb_data;
    logic                   issue_valid;
    logic                   issue_ready;
    operation_specification issue_op_spec;
    logic [63:0]            issue_lhs;
    logic [63:0]            issue_rhs;
    logic [3:0]             issue_dest_tag;
    logic [2:0]             occupancy;

    alu_reservation_station #(
        .DATA_WIDTH(64),
        .DEPTH     (4),
        .TAG_WIDTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_op_spec  (alloc_op_spec),
        .alloc_lhs      (alloc_lhs),
        .alloc_lhs_valid(alloc_lhs_valid),
        .alloc_lhs_tag  (alloc_lhs_tag),
        .alloc_rhs      (alloc_rhs),
        .alloc_rhs_valid(alloc_rhs_valid),
        .alloc_rhs_tag  (alloc_rhs_tag),
        .alloc_dest_tag (alloc_dest_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_op_spec  (issue_op_spec),
        .issue_lhs      (issue_lhs),
        .issue_rhs      (issue_rhs),
        .issue_dest_tag (issue_dest_tag),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] lhs;
        logic [63:0] rhs;
        logic [3:0]  dest;
        logic [3:0]  opcode;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] lhs, input logic [63:0] rhs, input logic [3:0] dest,
                        input logic [3:0] opcode);
        exp_t e;
        e.lhs = lhs; e.rhs = rhs; e.dest = dest; e.opcode = opcode;
        sb.push_back(e);
    endtask

    // Drives one alloc for a single cycle; any cdb/flush set by the caller rides along.
    task automatic do_alloc(input logic [3:0] opcode, input logic [63:0] lhs, input logic lv,
                            input logic [3:0] lt, input logic [63:0] rhs, input logic rv,
                            input logic [3:0] rt, input logic [3:0] dest);
        alloc_op_spec.opcode   = opcode;
        alloc_op_spec.i_format = 1'b0;
        alloc_lhs       = lhs;
        alloc_lhs_valid = lv;
        alloc_lhs_tag   = lt;
        alloc_rhs       = rhs;
        alloc_rhs_valid = rv;
        alloc_rhs_tag   = rt;
        alloc_dest_tag  = dest;
        alloc_valid     = 1'b1;
        tick();
        alloc_valid     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_issue", 64'(issue_dest_tag), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_lhs", issue_lhs, e.lhs);
                check("issue_rhs", issue_rhs, e.rhs);
                check("issue_dest_tag", 64'(issue_dest_tag), 64'(e.dest));
                check("issue_opcode", 64'(issue_op_spec.opcode), 64'(e.opcode));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0;
        alloc_op_spec = '0; alloc_lhs = '0; alloc_lhs_valid = 1'b0; alloc_lhs_tag = '0;
        alloc_rhs = '0; alloc_rhs_valid = 1'b0; alloc_rhs_tag = '0; alloc_dest_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_occupancy", 64'(occupancy), 64'd0);
        check("reset_issue_valid", 64'(issue_valid), 64'd0);
        check("reset_alloc_ready", 64'(alloc_ready), 64'd1);

        // Simple ready ADD
        issue_ready = 1'b1;
        push(64'd5, 64'd7, 4'd3, 4'd1);
        do_alloc(4'd1, 64'd5, 1'b1, 4'd0, 64'd7, 1'b1, 4'd0, 4'd3);
        check("add_issue_valid", 64'(issue_valid), 64'd1);
        check("add_occ_1", 64'(occupancy), 64'd1);
        tick();
        check("add_occ_0", 64'(occupancy), 64'd0);
        check("add_issue_idle", 64'(issue_valid), 64'd0);

        // Pending lhs woken by a later broadcast
        push(64'h10, 64'd1, 4'd4, 4'd2);
        do_alloc(4'd2, 64'd0, 1'b0, 4'd9, 64'd1, 1'b1, 4'd0, 4'd4);
        check("wait_not_ready_0", 64'(issue_valid), 64'd0);
        tick();
        check("wait_not_ready_1", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 64'h10;
        tick();
        cdb_valid = 1'b0;
        check("wake_issue_valid", 64'(issue_valid), 64'd1);
        tick();
        check("wake_occ_0", 64'(occupancy), 64'd0);

        // Broadcast in the alloc cycle
        push(64'hAB, 64'd3, 4'd5, 4'd3);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 64'hAB;
        do_alloc(4'd3, 64'd0, 1'b0, 4'd2, 64'd3, 1'b1, 4'd0, 4'd5);
        cdb_valid = 1'b0;
        check("bypass_issue_valid", 64'(issue_valid), 64'd1);
        tick();

        // Both operands wake on one broadcast
        push(64'h55, 64'h55, 4'd6, 4'd4);
        do_alloc(4'd4, 64'd0, 1'b0, 4'd7, 64'd0, 1'b0, 4'd7, 4'd6);
        check("both_pending", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 64'h55;
        tick();
        cdb_valid = 1'b0;
        check("both_wake_valid", 64'(issue_valid), 64'd1);
        tick();

        // Fill, overflow attempt, then drain
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(64'(100 + k), 64'(200 + k), 4'(6 + k), 4'd1);
            do_alloc(4'd1, 64'(100 + k), 1'b1, 4'd0, 64'(200 + k), 1'b1, 4'd0, 4'(6 + k));
        end
        check("full_alloc_ready", 64'(alloc_ready), 64'd0);
        check("full_occ", 64'(occupancy), 64'd4);
        do_alloc(4'd1, 64'd999, 1'b1, 4'd0, 64'd999, 1'b1, 4'd0, 4'd10);
        check("overflow_occ", 64'(occupancy), 64'd4);
        check("hold_dest", 64'(issue_dest_tag), 64'd6);
        issue_ready = 1'b1;
        tick();
        check("drain_alloc_ready", 64'(alloc_ready), 64'd1);
        check("drain_occ_3", 64'(occupancy), 64'd3);
        tick(); tick(); tick();
        check("drain_occ_0", 64'(occupancy), 64'd0);

        // Selection policy after slot 0 is refilled
        issue_ready = 1'b0;
        push(64'd11, 64'd0, 4'd11, 4'd5);
`ifdef ALU_RS_OLDEST_FIRST_EN
        for (int k = 1; k < 4; k++) push(64'(11 + k), 64'd0, 4'(11 + k), 4'd5);
        push(64'd15, 64'd0, 4'd15, 4'd5);
`else
        push(64'd15, 64'd0, 4'd15, 4'd5);
        for (int k = 1; k < 4; k++) push(64'(11 + k), 64'd0, 4'(11 + k), 4'd5);
`endif
        for (int k = 0; k < 4; k++) begin
            do_alloc(4'd5, 64'(11 + k), 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'(11 + k));
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        do_alloc(4'd5, 64'd15, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 4'd15);
`ifdef ALU_RS_OLDEST_FIRST_EN
        check("policy_head", 64'(issue_dest_tag), 64'd12);
`else
        check("policy_head", 64'(issue_dest_tag), 64'd15);
`endif
        issue_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("policy_occ_0", 64'(occupancy), 64'd0);

        // Flush beats alloc and wakeup
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_alloc(4'd6, 64'd0, 1'b0, 4'd1, 64'd0, 1'b1, 4'd0, 4'(k));
        end
        check("preflush_occ", 64'(occupancy), 64'd3);
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 64'h77;
        do_alloc(4'd6, 64'd1, 1'b1, 4'd0, 64'd2, 1'b1, 4'd0, 4'd13);
        flush = 1'b0;
        cdb_valid = 1'b0;
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_issue_valid", 64'(issue_valid), 64'd0);
        check("flush_alloc_ready", 64'(alloc_ready), 64'd1);

        issue_ready = 1'b1;
        push(64'd21, 64'd22, 4'd14, 4'd7);
        do_alloc(4'd7, 64'd21, 1'b1, 4'd0, 64'd22, 1'b1, 4'd0, 4'd14);
        check("postflush_issue", 64'(issue_valid), 64'd1);
        tick(); tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
